// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; drives the HI/LO write port.
// result_o = {remainder, quotient}, valid while ready_o is high.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic [1:0]         state_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2*WIDTH:0] r_work;
  logic [WIDTH-1:0] r_divisor;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [2*WIDTH+1:0] w_shift;
  logic [WIDTH+1:0]   w_upper;
  logic [WIDTH+1:0]   w_trial;
  logic               w_borrow;
  logic [2*WIDTH:0]   w_step;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Signed operands are divided as magnitudes; signs are reapplied at the end.
  assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // One restoring step: shift left, try subtracting the divisor from the upper half.
  assign w_shift  = {r_work, 1'b0};
  assign w_upper  = w_shift[2*WIDTH+1:WIDTH];
  assign w_trial  = w_upper - {2'b00, r_divisor};
  assign w_borrow = w_trial[WIDTH+1];
  assign w_step   = w_borrow ? w_shift[2*WIDTH:0]
                             : {w_trial[WIDTH:0], w_shift[WIDTH-1:1], 1'b1};

  assign w_quo     = r_work[WIDTH-1:0];
  assign w_rem     = r_work[2*WIDTH-1:WIDTH];
  assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
  assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

  assign state_o = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FREE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            r_work    <= {{(WIDTH+1){1'b0}}, w_abs1};
            r_divisor <= w_abs2;
            r_neg_q   <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg_r   <= signed_div_i & opdata1_i[WIDTH-1];
            r_cnt     <= '0;
            r_state   <= (opdata2_i == '0) ? S_BY_ZERO : S_ON;
          end
        end
        S_BY_ZERO: begin
          r_cnt <= '0;
          if (annul_i) begin
            r_state <= S_FREE;
          end else begin
            r_state  <= S_END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_state <= S_FREE;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(WIDTH)) begin
            r_state  <= S_END;
            result_o <= {w_rem_fix, w_quo_fix};
            ready_o  <= 1'b1;
          end else begin
            r_work <= w_step;
            r_cnt  <= r_cnt + CW'(1);
          end
        end
        S_END: begin
          // EX holds start_i until it has consumed the result.
          if (annul_i || !start_i) begin
            r_state  <= S_FREE;
            r_cnt    <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_FREE;
          r_cnt   <= '0;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
